// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    LOAD   = 3'd5
  } rx_state_t;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int PARITY_MAX_W      = 16;

  // Returns 1 when the (zero-extended) bit group holds an odd number of ones.
  function automatic logic even_parity_bad(input logic [PARITY_MAX_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_rx_core_stp_sr.sv
// flex_stp_sr: serial-to-parallel shift register, resets to all ones.
module flex_stp_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  logic [NUM_BITS-1:0] shift_r;

  // Shift register; SHIFT_MSB=0 enters new bits at the MSB so the first bit ends at bit 0.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      shift_r <= {NUM_BITS{1'b1}};
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        shift_r <= {shift_r[NUM_BITS-2:0], serial_in};
      end else begin
        shift_r <= {serial_in, shift_r[NUM_BITS-1:1]};
      end
    end else begin
      shift_r <= shift_r;
    end
  end

  assign parallel_out = shift_r;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling and ready/read handshake.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int NUM_DATA_BITS = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT  = 10
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     serial_in,
  input  logic                     data_read,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     data_ready,
  output logic                     overrun_error,
  output logic                     framing_error,
  output logic                     parity_error
);

  localparam int BIT_CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int DATA_CNT_W = $clog2(NUM_DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0]  HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DATA_CNT_W-1:0] DATA_LAST = DATA_CNT_W'(NUM_DATA_BITS - 1);

  logic                     sync1_r, sync2_r, prev_r;
  logic                     start_edge_s, bit_last_s, shift_en_s, parity_ok_s;
  rx_state_t                state_r;
  logic [BIT_CNT_W-1:0]     bit_cnt_r;
  logic [DATA_CNT_W-1:0]    data_cnt_r;
  logic                     stop_bit_r;
  logic [NUM_DATA_BITS-1:0] shift_data_s;
  logic [NUM_DATA_BITS-1:0] rx_data_r;
  logic                     data_ready_r, overrun_r, framing_r, parity_err_r;

  // Two-flop synchronizer followed by the edge-detect history flop.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= serial_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign start_edge_s = prev_r & ~sync2_r;
  assign bit_last_s   = (bit_cnt_r == BIT_LAST);
  assign shift_en_s   = (state_r == DATA) && bit_last_s;

  flex_stp_sr #(
    .NUM_BITS  (NUM_DATA_BITS),
    .SHIFT_MSB (1'b0)
  ) u_shift (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_en_s),
    .serial_in    (sync2_r),
    .parallel_out (shift_data_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bit_r;

  // Captures the received parity bit mid-period.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      parity_bit_r <= 1'b0;
    end else if (state_r == PARITY && bit_last_s) begin
      parity_bit_r <= sync2_r;
    end else begin
      parity_bit_r <= parity_bit_r;
    end
  end

  assign parity_ok_s = ~even_parity_bad(PARITY_MAX_W'({parity_bit_r, shift_data_s}));
`else
  assign parity_ok_s = 1'b1;
`endif

  // Receive FSM, bit/data counters and registered handshake/error outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      bit_cnt_r    <= BIT_CNT_W'(0);
      data_cnt_r   <= DATA_CNT_W'(0);
      stop_bit_r   <= 1'b0;
      rx_data_r    <= NUM_DATA_BITS'(0);
      data_ready_r <= 1'b0;
      overrun_r    <= 1'b0;
      framing_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_edge_s) begin
            bit_cnt_r    <= BIT_CNT_W'(0);
            data_cnt_r   <= DATA_CNT_W'(0);
            framing_r    <= 1'b0;
            parity_err_r <= 1'b0;
            state_r      <= START;
          end
        end
        START: begin
          if (bit_cnt_r == HALF_LAST) begin
            bit_cnt_r <= BIT_CNT_W'(0);
            // A line already back high at mid-start is a glitch.
            state_r   <= sync2_r ? IDLE : DATA;
          end else begin
            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_last_s) begin
            bit_cnt_r  <= BIT_CNT_W'(0);
            data_cnt_r <= data_cnt_r + DATA_CNT_W'(1);
            if (data_cnt_r == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_last_s) begin
            bit_cnt_r <= BIT_CNT_W'(0);
            state_r   <= STOP;
          end else begin
            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_last_s) begin
            bit_cnt_r  <= BIT_CNT_W'(0);
            stop_bit_r <= sync2_r;
            state_r    <= LOAD;
          end else begin
            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
          end
        end
        LOAD: begin
          state_r <= IDLE;
          if (stop_bit_r && parity_ok_s) begin
            rx_data_r    <= shift_data_s;
            data_ready_r <= 1'b1;
            if (data_ready_r && !data_read) begin
              overrun_r <= 1'b1;
            end
          end else begin
            framing_r    <= ~stop_bit_r;
            parity_err_r <= ~parity_ok_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (state_r != LOAD && data_read) begin
        data_ready_r <= 1'b0;
        overrun_r    <= 1'b0;
      end
    end
  end

  assign rx_data       = rx_data_r;
  assign data_ready    = data_ready_r;
  assign overrun_error = overrun_r;
  assign framing_error = framing_r;
  assign parity_error  = parity_err_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core (8 data bits, 10 clocks per bit).
module tb_uart_rx_core;

  localparam int N    = 8;
  localparam int C    = 10;
  localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 2 + 1 + HALF + (N + 1 + PB) * C + 1;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         serial_in = 1'b1;
  logic         data_read = 1'b0;
  logic [N-1:0] rx_data;
  logic         data_ready, overrun_error, framing_error, parity_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fall_cyc = -1;
  int rise_cyc = -1;
  logic dr_prev = 1'b0;

  uart_rx_core #(.NUM_DATA_BITS(N), .CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;

  // Cycle counter and data_ready rise detector, sampled 1ns after each edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (data_ready && !dr_prev) rise_cyc = cyc;
      dr_prev = data_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] d, input logic rdy,
                           input logic ovr, input logic frm);
    check_eq({tag, "_data"},    32'(rx_data),       32'(d));
    check_eq({tag, "_ready"},   32'(data_ready),    32'(rdy));
    check_eq({tag, "_overrun"}, 32'(overrun_error), 32'(ovr));
    check_eq({tag, "_framing"}, 32'(framing_error), 32'(frm));
    check_eq({tag, "_parity"},  32'(parity_error),  32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    tick(C);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop_bit);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < N; i++) send_bit(d[i]);
    if (PB == 1) send_bit(^d);
    send_bit(stop_bit);
    serial_in = 1'b1;
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
  endtask

  initial begin
    logic [N-1:0] partial;
    tick(3);
    n_rst = 1'b1;
    tick(200);
    check_all("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    rise_cyc = -1;
    send_frame(8'hA5, 1'b1);
    check_eq("a5_latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
    check_all("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    read_pulse();
    check_eq("a5_read_ready", 32'(data_ready), 32'd0);
    tick(5);

    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(50);
    check_all("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

    send_frame(8'h3C, 1'b0);
    tick(5);
    check_all("framing", 8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b1);
    tick(2);
    check_all("after_ferr", 8'h0F, 1'b1, 1'b0, 1'b0);
    read_pulse();
    tick(2);

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    check_all("overrun", 8'h22, 1'b1, 1'b1, 1'b0);
    read_pulse();
    check_eq("ovr_read_ready",   32'(data_ready),    32'd0);
    check_eq("ovr_read_overrun", 32'(overrun_error), 32'd0);
    tick(5);

    partial = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i]);
    n_rst = 1'b0;
    serial_in = 1'b1;
    tick(2);
    n_rst = 1'b1;
    check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(20);
    send_frame(8'h77, 1'b1);
    tick(2);
    check_all("post_reset", 8'h77, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receiver for the 8N1-style link that the transmit-side parallel-to-serial shifter drives.
- Synchronizes `serial_in`, detects the start bit and samples each bit mid-period with a cycle counter.
- Shifts bits in LSB-first, checks the stop bit, and presents a parallel word with a ready/read handshake plus error flags.
- Idle line level is 1.

Parameters:
- `NUM_DATA_BITS`, 8, data bits per frame.
- `CLKS_PER_BIT`, 10, clk cycles per bit period; must be ≥ 4 and even.

Ports:
- `clk`  input  1  system clock, rising edge
- `n_rst`  input  1  synchronous active-low reset
- `serial_in`  input  1  asynchronous serial line, idle high
- `data_read`  input  1  consumer pulse acknowledging `rx_data`
- `rx_data`  output  NUM_DATA_BITS  last good received word
- `data_ready`  output  1  `rx_data` holds an unread word
- `overrun_error`  output  1  a new word overwrote an unread word
- `framing_error`  output  1  last frame had stop bit = 0
- `parity_error`  output  1  last frame failed even parity; tied 0 without the macro

Behaviour:
- Reset is sampled on the `clk` rising edge when `n_rst` = 0. Reset values:
  - both sync flops = 1; state = IDLE; counters = 0; shift reg = all 1s
  - `rx_data` = 0; `data_ready` = 0; all error flags = 0
- Reset mid-frame abandons the frame with no flag updates.
- Synchronizer: two flops, then a one-flop edge detector. `start_edge` = previous synced value 1 and current synced value 0.
- `HALF` = CLKS_PER_BIT/2. `bit_cnt` counts 0..CLKS_PER_BIT-1; `data_cnt` counts 0..NUM_DATA_BITS.
- IDLE: on `start_edge`, clear `bit_cnt`, clear `framing_error` and `parity_error`, go to START.
- START: at `bit_cnt` == HALF-1, sample the synced line.
  - Line = 0: clear `bit_cnt` and go to DATA.
  - Line = 1: treat as a glitch and return to IDLE with no flag change.
- DATA: at `bit_cnt` == CLKS_PER_BIT-1, shift the synced bit into the MSB of the shift reg (right shift, so the first bit ends at bit 0) and increment `data_cnt`.
  - After NUM_DATA_BITS samples, go to PARITY if the macro is defined, else STOP.
- STOP: at `bit_cnt` == CLKS_PER_BIT-1, latch the stop bit and go to LOAD.
- LOAD (one cycle), then return to IDLE:
  - Stop bit = 1: `rx_data` ← shift reg and `data_ready` ← 1.
    - If `data_ready` was already 1 and `data_read` = 0 this cycle, set `overrun_error`; new data still overwrites.
  - Stop bit = 0: set `framing_error`; `rx_data` and `data_ready` are unchanged.
- `data_read`:
  - `data_read` = 1 in any non-LOAD cycle clears `data_ready` and `overrun_error` on the next edge.
  - In the LOAD cycle the load wins: `data_ready` stays 1 and no overrun is flagged.
- `start_edge` outside IDLE is ignored.
- Because STOP samples mid-bit, a back-to-back frame's start edge occurs at or after the IDLE return, so it is still caught.
- Latency: the `data_ready` rise occurs 2 (sync) + 1 (edge) + HALF + (NUM_DATA_BITS+1)·CLKS_PER_BIT + 1 cycles after the line falls.

Optional Feature:
- Macro `UART_RX_PARITY_EN`.
- Defined:
  - Adds a PARITY state after DATA, one bit period long, sampled at CLKS_PER_BIT-1.
  - Even parity over data + parity bit.
  - Mismatch sets `parity_error` in LOAD and suppresses the load, as for a framing error.
- Undefined: no PARITY state; `parity_error` is constant 0.

Decomposition:
- Package `uart_rx_pkg`: state enum `rx_state_t` {IDLE, START, DATA, PARITY, STOP, LOAD}, 3-bit encoding; a default-width localparam.
- Sub-module `flex_stp_sr`: serial-to-parallel shifter with parameters NUM_BITS and SHIFT_MSB, shift_enable, reset value all 1s.
- The FSM, counters and synchronizer live in `uart_rx_core`.

Test Plan:
- Reset then idle line held 1 for 200 cycles -> `data_ready` = 0, all flags = 0, `rx_data` = 0x00.
- Frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) at CLKS_PER_BIT = 10 -> `data_ready` rises at the computed latency, `rx_data` = 0xA5, no errors; `data_read` pulse -> `data_ready` = 0 next cycle.
- Start glitch: line low for 3 cycles then high -> stays IDLE, `data_ready` = 0, no flags.
- Frame 0x3C with stop bit = 0 -> `framing_error` = 1, `rx_data` keeps the prior 0xA5, `data_ready` unchanged; next good frame 0x0F clears `framing_error`, `rx_data` = 0x0F.
- Two back-to-back frames 0x11 then 0x22 without `data_read` -> `rx_data` = 0x22, `overrun_error` = 1; `data_read` clears `overrun_error` and `data_ready`.
- `n_rst` = 0 mid-DATA of frame 0x55, then a full 0x77 frame -> after reset all outputs at reset values; the 0x77 frame is received cleanly.
